stream_demux_n: RTL and testbench

STREAM_DEMUX_N -- requirements
Module: stream_demux_n

---
 rtl/stream_demux_pkg.sv | 14 +
 rtl/sat_counter.sv | 28 ++
 rtl/stream_demux_n.sv | 142 ++++++++++++++
 tb/tb_stream_demux_n.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
//   state_t    : packet-level FSM state (IDLE, FWD, DROP)
//   DROP_CNT_W : width of the dropped-packet counter
package stream_demux_pkg;

   localparam int unsigned DROP_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk, rst : clock and synchronous active-high reset
//   i_inc    : count one event this cycle
//   o_count  : current count
module sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] MAX_CNT = '1;

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != MAX_CNT)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/stream_demux_n.sv
// Packet-aware 1-to-N stream demultiplexer with a single holding register.
// The first beat of a packet selects the channel; the rest of the packet
// follows it. Packets with an out-of-range select are swallowed and counted.
//   clk, rst              : clock, synchronous active-high reset
//   en                    : global accept enable
//   in_valid/in_ready     : input handshake; in_data, in_sel, in_last payload
//   out_valid/out_ready   : per-channel handshake (out_valid one-hot or zero)
//   out_data, out_last    : held beat, shared by all channels
//   drop_cnt              : saturating count of dropped packets
module stream_demux_n
   import stream_demux_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_CH   = 4,
   parameter int unsigned SEL_W  = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic                  in_last,
   output logic [N_CH-1:0]       out_valid,
   input  logic [N_CH-1:0]       out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_last,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   state_t              r_state;
   state_t              w_next;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic                r_last;
   logic [SEL_W-1:0]    r_hold_ch;
   logic [SEL_W-1:0]    r_lock_ch;

   logic [N_CH-1:0]     w_out_valid;
   logic                w_out_fire;
   logic                w_in_ready;
   logic                w_in_fire;
   logic                w_sel_ok;
   logic                w_load;
   logic                w_drop;
   logic [SEL_W-1:0]    w_load_ch;

   // Channel decode of the held beat.
   always_comb begin
      w_out_valid = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         w_out_valid[k] = r_valid && (r_hold_ch == SEL_W'(k));
      end
   end

   assign w_out_fire = |(w_out_valid & out_ready);

   // DROP never loads the register, so it need not wait for a drain.
   always_comb begin
      w_in_ready = 1'b0;
      if (!rst && en) begin
         w_in_ready = (r_state == DROP) || !r_valid || w_out_fire;
      end
   end

   assign w_in_fire = in_valid && w_in_ready;
   assign w_sel_ok  = {1'b0, in_sel} < (SEL_W+1)'(N_CH);

   // Next-state and holding-register load decisions.
   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_drop    = 1'b0;
      w_load_ch = r_lock_ch;
      case (r_state)
         IDLE: begin
            if (w_in_fire) begin
               if (w_sel_ok) begin
                  w_load    = 1'b1;
                  w_load_ch = in_sel;
                  if (!in_last) w_next = FWD;
               end else begin
                  w_drop = 1'b1;
                  if (!in_last) w_next = DROP;
               end
            end
         end
         FWD: begin
            if (w_in_fire) begin
               w_load = 1'b1;
               if (in_last) w_next = IDLE;
            end
         end
         DROP: begin
            if (w_in_fire && in_last) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Holding register and locked channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_last    <= 1'b0;
         r_hold_ch <= '0;
         r_lock_ch <= '0;
      end else begin
         if (w_load) begin
            r_valid   <= 1'b1;
            r_data    <= in_data;
            r_last    <= in_last;
            r_hold_ch <= w_load_ch;
            r_lock_ch <= w_load_ch;
         end else if (w_out_fire) begin
            r_valid <= 1'b0;
         end
      end
   end

   sat_counter #(
      .WIDTH (DROP_CNT_W)
   ) u_drop_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_drop),
      .o_count (drop_cnt)
   );

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = r_data;
   assign out_last  = r_last;

endmodule

// File: tb/tb_stream_demux_n.sv
// Testbench for stream_demux_n: a 4-channel and a 3-channel instance share
// the input stimulus; each is compared every cycle against a packet-level
// reference model, plus directed scenarios with fixed expectations.
module tb_stream_demux_n;

   logic       clk;
   logic       rst;
   logic       en;
   logic       in_valid;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic       in_last;
   logic [3:0] out_ready;

   logic       rdy4, ol4, rdy3, ol3;
   logic [3:0] ov4;
   logic [2:0] ov3;
   logic [7:0] od4, od3, dc4, dc3;

   stream_demux_n #(.DATA_W(8), .N_CH(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy4),
      .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .out_last(ol4), .drop_cnt(dc4));

   stream_demux_n #(.DATA_W(8), .N_CH(3)) dut3 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy3),
      .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
      .out_valid(ov3), .out_ready(out_ready[2:0]), .out_data(od3),
      .out_last(ol3), .drop_cnt(dc3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Packet-level reference model, index 0 = 4 channels, 1 = 3 channels.
   typedef enum int {M_IDLE, M_FWD, M_DROP} mstate_t;
   mstate_t    m_st   [2];
   bit         m_hv   [2];
   logic [7:0] m_hd   [2];
   bit         m_hl   [2];
   int         m_hc   [2];
   int         m_lock [2];
   int         m_cnt  [2];

   function automatic int nch_of(input int m);
      return (m == 0) ? 4 : 3;
   endfunction

   function automatic bit exp_rdy(input int m);
      bit drain = m_hv[m] && (out_ready[2'(m_hc[m])] == 1'b1);
      return !rst && en && (m_st[m] == M_DROP || !m_hv[m] || drain);
   endfunction

   task automatic model_reset(input int m);
      m_st[m] = M_IDLE; m_hv[m] = 0; m_hd[m] = '0; m_hl[m] = 0;
      m_hc[m] = 0; m_lock[m] = 0; m_cnt[m] = 0;
   endtask

   task automatic model_load(input int m, input int ch);
      m_hv[m] = 1; m_hd[m] = in_data; m_hl[m] = in_last; m_hc[m] = ch;
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         bit rdy  = exp_rdy(m);
         bit fire = m_hv[m] && (out_ready[2'(m_hc[m])] == 1'b1);
         if (rst) begin
            model_reset(m);
         end else begin
            if (fire) m_hv[m] = 0;
            if (in_valid && rdy) begin
               case (m_st[m])
                  M_IDLE: begin
                     if (int'(in_sel) < nch_of(m)) begin
                        m_lock[m] = int'(in_sel);
                        model_load(m, m_lock[m]);
                        if (!in_last) m_st[m] = M_FWD;
                     end else begin
                        if (m_cnt[m] < 255) m_cnt[m]++;
                        if (!in_last) m_st[m] = M_DROP;
                     end
                  end
                  M_FWD: begin
                     model_load(m, m_lock[m]);
                     if (in_last) m_st[m] = M_IDLE;
                  end
                  default: if (in_last) m_st[m] = M_IDLE;
               endcase
            end
         end
      end
   endtask

   task automatic check_outputs();
      for (int m = 0; m < 2; m++) begin
         logic [3:0] gov;
         logic       grdy, gl;
         logic [7:0] gd, gc;
         int         eov;
         int         n = nch_of(m);
         if (m == 0) begin gov = ov4; grdy = rdy4; gd = od4; gl = ol4; gc = dc4; end
         else        begin gov = {1'b0, ov3}; grdy = rdy3; gd = od3; gl = ol3; gc = dc3; end
         eov = m_hv[m] ? (1 << m_hc[m]) : 0;
         check($sformatf("n%0d_out_valid", n), 32'(gov), eov);
         check($sformatf("n%0d_in_ready", n), 32'(grdy), 32'(exp_rdy(m)));
         check($sformatf("n%0d_drop_cnt", n), 32'(gc), m_cnt[m]);
         if (m_hv[m]) begin
            check($sformatf("n%0d_out_data", n), 32'(gd), 32'(m_hd[m]));
            check($sformatf("n%0d_out_last", n), 32'(gl), 32'(m_hl[m]));
         end
      end
   endtask

   // One cycle: compare at the falling edge, advance the model at the rising edge.
   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] s, input bit l);
      in_valid = v; in_data = d; in_sel = s; in_last = l;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; out_ready = 4'hF;
      drive(0, 8'h00, 2'd0, 0);
      model_reset(0); model_reset(1);
      tick(); tick();
      check("rst_out_valid", 32'(ov4), 0);
      check("rst_out_data", 32'(od4), 0);
      check("rst_out_last", 32'(ol4), 0);
      check("rst_drop_cnt", 32'(dc3), 0);
      check("rst_in_ready", 32'(rdy4), 0);
      rst = 1'b0;

      // Three-beat packet on channel 2
      drive(1, 8'hA1, 2'd2, 0); tick();
      check("p3_valid1", 32'(ov4), 4); check("p3_data1", 32'(od4), 'hA1);
      drive(1, 8'hA2, 2'd2, 0); tick();
      check("p3_valid2", 32'(ov4), 4); check("p3_data2", 32'(od4), 'hA2);
      drive(1, 8'hA3, 2'd2, 1); tick();
      check("p3_valid3", 32'(ov4), 4); check("p3_data3", 32'(od4), 'hA3);
      check("p3_last3", 32'(ol4), 1);
      drive(0, 8'h00, 2'd0, 0); tick();
      check("p3_idle", 32'(ov4), 0);

      // Backpressure on channel 1
      out_ready = 4'b1101;
      drive(1, 8'h55, 2'd1, 1); tick();
      check("bp_valid", 32'(ov4), 2);
      drive(1, 8'h66, 2'd0, 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", 32'(rdy4), 0);
         tick();
         check("bp_hold_data", 32'(od4), 'h55);
         check("bp_hold_valid", 32'(ov4), 2);
      end
      out_ready = 4'hF;
      #1;
      check("bp_release_rdy", 32'(rdy4), 1);
      tick();
      check("bp_next_valid", 32'(ov4), 1); check("bp_next_data", 32'(od4), 'h66);
      drive(0, 8'h00, 2'd0, 0); tick();

      // Select changes mid-packet are ignored
      drive(1, 8'h10, 2'd0, 0); tick(); check("lock_v0", 32'(ov4), 1);
      drive(1, 8'h11, 2'd3, 0); tick(); check("lock_v1", 32'(ov4), 1);
      drive(1, 8'h12, 2'd3, 1); tick(); check("lock_v2", 32'(ov4), 1);
      check("lock_last", 32'(ol4), 1);
      drive(0, 8'h00, 2'd0, 0); tick();

      // Back-to-back single-beat packets
      drive(1, 8'h21, 2'd1, 1); tick(); check("b2b_v1", 32'(ov4), 2);
      drive(1, 8'h22, 2'd3, 1);
      #1; check("b2b_rdy", 32'(rdy4), 1);
      tick(); check("b2b_v3", 32'(ov4), 8); check("b2b_d3", 32'(od4), 'h22);
      drive(0, 8'h00, 2'd0, 0); tick();

      // Reset in the middle of a packet with a held beat
      out_ready = 4'h0;
      drive(1, 8'h31, 2'd2, 0); tick(); check("mrst_held", 32'(ov4), 4);
      drive(1, 8'h32, 2'd2, 0); rst = 1'b1;
      #1; check("mrst_rdy", 32'(rdy4), 0);
      tick();
      check("mrst_valid", 32'(ov4), 0); check("mrst_data", 32'(od4), 0);
      rst = 1'b0; out_ready = 4'hF;
      drive(1, 8'h33, 2'd0, 1); tick();
      check("mrst_first", 32'(ov4), 1); check("mrst_first_d", 32'(od4), 'h33);
      drive(0, 8'h00, 2'd0, 0); tick();

      // Illegal select on the 3-channel instance, up to saturation
      rst = 1'b1; tick(); rst = 1'b0;
      for (int p = 0; p < 300; p++) begin
         drive(1, 8'(p), 2'd3, 0); tick();
         if (p == 0) check("drop_first", 32'(dc3), 1);
         check("drop_no_valid", 32'(ov3), 0);
         drive(1, 8'(p), 2'd3, 1); tick();
      end
      check("drop_sat", 32'(dc3), 255);
      check("drop_pow2", 32'(dc4), 0);
      drive(0, 8'h00, 2'd0, 0); tick();

      // Randomised traffic
      rst = 1'b1; tick(); rst = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         en        = ($urandom_range(0, 7) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_sel    = 2'($urandom);
         in_last   = ($urandom_range(0, 2) == 0);
         out_ready = 4'($urandom | $urandom);
         tick();
      end

      rst = 1'b1; en = 1'b1; drive(0, 8'h00, 2'd0, 0); tick();
      check("end_valid", 32'(ov4), 0);
      check("end_drop_cnt", 32'(dc3), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
